instr_loader: RTL

Boot-time program loader that sits directly upstream of the CPU top level and drives its instruction-memory write port (w_en, cpu_in).
- Accepts a little-endian byte stream over a valid/ready handshake.
- Assembles the bytes into 32-bit instruction words and buffers them in a small word FIFO.
- Emits one word per w_en pulse.
- busy/done tell the system when the program image is fully written and the core may run.

---
 rtl/instr_loader.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/instr_loader.sv
// instr_loader: boot-time program loader feeding the CPU instruction-memory
// write port.
//   - Takes a little-endian byte stream over byte_valid/byte_ready.
//   - Packs the bytes into 32-bit words and buffers them in a FIFO_DEPTH-entry
//     word FIFO.
//   - Emits one word per w_en pulse on cpu_in.
//
// Ports:
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   start, word_count   : begin a load of word_count words (sampled in IDLE only)
//   byte_in/valid/ready : byte stream handshake
//   w_en, cpu_in        : one-cycle write strobe and instruction word
//   busy, done, loaded  : load in progress, end-of-load pulse, words emitted
//   csum_err            : checksum mismatch flag
//
// Optional feature: define INSTR_LOADER_CHECKSUM_EN to add a trailing 4-byte
// checksum (mod 2^32 sum of all words) that is verified before done. Without
// the macro, csum_err is tied to 0.
module instr_loader #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] word_count,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    output logic             w_en,
    output logic [31:0]      cpu_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] loaded,
    output logic             csum_err
);
    localparam int AW = $clog2(FIFO_DEPTH);

`ifdef INSTR_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CSUM, S_DRAIN, S_FINISH} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_FINISH} state_t;
`endif

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt, r_acc, r_loaded;
    logic [1:0]       r_idx;
    logic [23:0]      r_asm;            // bytes 0..2 of the word being built
    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [AW:0]      r_count;
    logic [31:0]      r_cpu_in;
    logic             r_w_en, r_busy, r_done;
    logic             w_full, w_take, w_push, w_pop, w_ready;
    logic [31:0]      w_word;

    assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_take = byte_valid && w_ready;
    assign w_word = {byte_in, r_asm};
    assign w_push = w_take && (r_idx == 2'd3) && (r_state == S_LOAD);
    assign w_pop  = (r_count != '0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            S_IDLE:
                if (start) w_next = (word_count == '0) ? S_FINISH : S_LOAD;
            S_LOAD: begin
                // Registered full flag: a same-cycle pop never lets us overflow.
                w_ready = !w_full && (r_acc < r_cnt);
                if (w_push && (r_acc + CNT_W'(1) == r_cnt))
`ifdef INSTR_LOADER_CHECKSUM_EN
                    w_next = S_CSUM;
`else
                    w_next = S_DRAIN;
`endif
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            S_CSUM: begin
                w_ready = 1'b1;
                if (w_take && r_idx == 2'd3) w_next = S_DRAIN;
            end
`endif
            // Wait for both the FIFO and the output register to go quiet.
            S_DRAIN:  if (r_count == '0 && !r_w_en) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // FIFO storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_loaded <= '0;
            r_idx    <= '0;
            r_asm    <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_cpu_in <= '0;
            r_w_en   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_take) begin
                r_idx <= r_idx + 2'd1;
                case (r_idx)
                    2'd0:    r_asm[7:0]   <= byte_in;
                    2'd1:    r_asm[15:8]  <= byte_in;
                    2'd2:    r_asm[23:16] <= byte_in;
                    default: ;
                endcase
            end
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
                r_acc  <= r_acc + CNT_W'(1);
            end
            r_w_en <= w_pop;
            if (w_pop) begin
                r_cpu_in <= r_mem[r_rptr];
                r_rptr   <= r_rptr + AW'(1);
                if (r_loaded != '1) r_loaded <= r_loaded + CNT_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: ;
            endcase
            if (r_state == S_IDLE && start) begin
                r_cnt    <= word_count;
                r_acc    <= '0;
                r_loaded <= '0;
                r_idx    <= '0;
                r_busy   <= 1'b1;
            end
            if (r_state == S_FINISH) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [31:0] r_sum, r_csum_rx;
    logic        r_csum_err;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum      <= '0;
            r_csum_rx  <= '0;
            r_csum_err <= 1'b0;
        end else begin
            if (w_push) r_sum <= r_sum + w_word;
            if (r_state == S_CSUM && w_take && r_idx == 2'd3) r_csum_rx <= w_word;
            if (r_state == S_IDLE && start) begin
                r_sum      <= '0;
                r_csum_rx  <= '0;
                r_csum_err <= 1'b0;
            end
            // Empty loads compare 0 against 0, so no error without checksum bytes.
            if (r_state == S_FINISH) r_csum_err <= (r_csum_rx != r_sum);
        end
    end
    assign csum_err = r_csum_err;
`else
    assign csum_err = 1'b0;
`endif

    assign byte_ready = w_ready;
    assign w_en       = r_w_en;
    assign cpu_in     = r_cpu_in;
    assign busy       = r_busy;
    assign done       = r_done;
    assign loaded     = r_loaded;
endmodule
